// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types for the ALU sequencer: internal-bus writer
//                select, ALU opcode, sequencer state, per-op core controls
//                and F-register bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Internal-bus writer select (also used by the ALU bench)
    typedef enum logic [2:0] {
        BUS_HIGHZ = 3'd0,
        BUS_OP1   = 3'd1,
        BUS_OP2   = 3'd2,
        BUS_RES   = 3'd3,
        BUS_SHIFT = 3'd4,
        BUS_BS    = 3'd5
    } bus_t;

    // Z80 ALU opcode order
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_ADC = 3'd1,
        OP_SUB = 3'd2,
        OP_SBC = 3'd3,
        OP_AND = 3'd4,
        OP_XOR = 3'd5,
        OP_OR  = 3'd6,
        OP_CP  = 3'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP1  = 3'd1,
        ST_OP2  = 3'd2,
        ST_LOW  = 3'd3,
        ST_HIGH = 3'd4,
        ST_READ = 3'd5,
        ST_RESP = 3'd6
    } state_t;

    // F register bit positions {SF,ZF,YF,HF,XF,PV,NF,CF}
    localparam int unsigned C_FLAG_CF = 0;
    localparam int unsigned C_FLAG_NF = 1;
    localparam int unsigned C_FLAG_PV = 2;
    localparam int unsigned C_FLAG_XF = 3;
    localparam int unsigned C_FLAG_HF = 4;
    localparam int unsigned C_FLAG_YF = 5;
    localparam int unsigned C_FLAG_ZF = 6;
    localparam int unsigned C_FLAG_SF = 7;

    function automatic logic is_sub(input alu_op_t op);
        return (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
    endfunction

    function automatic logic is_arith(input alu_op_t op);
        return (op == OP_ADD) || (op == OP_ADC) || is_sub(op);
    endfunction

    // Core controls {R, S, V, neg}
    function automatic logic [3:0] op_ctrl(input alu_op_t op);
        logic [2:0] rsv;
        case (op)
            OP_AND:  rsv = 3'b110;
            OP_OR:   rsv = 3'b010;
            OP_XOR:  rsv = 3'b001;
            default: rsv = 3'b000;
        endcase
        return {rsv, is_sub(op)};
    endfunction

    // Carry into the low nibble; subtraction is a + ~b + 1 (SBC: + ~cf)
    function automatic logic carry_in0(input alu_op_t op, input logic cf);
        case (op)
            OP_ADC:         return cf;
            OP_SUB, OP_CP:  return 1'b1;
            OP_SBC:         return ~cf;
            default:        return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_flags.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_flags
//  Description : Combinational assembly of the Z80 F register from the
//                captured ALU status of one operation.
//  Ports       : i_op     - operation being completed
//                i_res    - result byte read back from the ALU
//                i_opb    - latched operand 2 (YF/XF source for CP)
//                i_hc     - carry out of the low nibble
//                i_cout   - carry out of the high nibble
//                i_vf     - core overflow
//                i_par    - core parity, 1 = even
//                o_flags  - {SF,ZF,YF,HF,XF,PV,NF,CF}
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_flags
    import alu_seq_pkg::*;
#(
    parameter bit CF_SUB_INVERT = 1'b1
) (
    input  alu_op_t    i_op,
    input  logic [7:0] i_res,
    input  logic [7:0] i_opb,
    input  logic       i_hc,
    input  logic       i_cout,
    input  logic       i_vf,
    input  logic       i_par,
    output logic [7:0] o_flags
);

    logic       w_sub;
    logic       w_arith;
    logic       w_inv;
    logic [7:0] w_xy_src;

    always_comb begin
        w_sub    = is_sub(i_op);
        w_arith  = is_arith(i_op);
        // Core computes a + ~b + 1, so its carry is "no borrow"
        w_inv    = w_sub & CF_SUB_INVERT;
        // CP copies the undocumented bits from the compared operand
        w_xy_src = (i_op == OP_CP) ? i_opb : i_res;

        o_flags            = 8'h00;
        o_flags[C_FLAG_SF] = i_res[7];
        o_flags[C_FLAG_ZF] = (i_res == 8'h00);
        o_flags[C_FLAG_YF] = w_xy_src[5];
        o_flags[C_FLAG_XF] = w_xy_src[3];
        o_flags[C_FLAG_NF] = w_sub;
        if (w_arith) begin
            o_flags[C_FLAG_CF] = i_cout ^ w_inv;
            o_flags[C_FLAG_HF] = i_hc ^ w_inv;
            o_flags[C_FLAG_PV] = i_vf;
        end else begin
            o_flags[C_FLAG_CF] = 1'b0;
            o_flags[C_FLAG_HF] = (i_op == OP_AND);
            o_flags[C_FLAG_PV] = i_par;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_sequencer
//  Description : Runs one 8-bit ALU operation through the nibble-serial ALU:
//                OP1 load, OP2 load, low nibble, high nibble, readback, then
//                presents result and F flags on a valid/ready response.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                req_*                      - request channel (valid/ready)
//                resp_*                     - response channel (valid/ready)
//                alu_db_out/oe, alu_db_in   - ALU external data bus
//                bus_sel                    - internal-bus writer select
//                alu_op1/op2_sel_bus        - operand latch strobes
//                alu_op_low, alu_sel_op2_*  - nibble / operand selects
//                alu_core_*, alu_parity_in  - core controls
//                alu_core_cf_out, alu_vf_out, alu_parity_out - core status
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter bit CF_SUB_INVERT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  alu_op_t    req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_b,
    input  logic       req_cf,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_result,
    output logic [7:0] resp_flags,
    output logic [7:0] alu_db_out,
    output logic       alu_db_oe,
    input  logic [7:0] alu_db_in,
    output bus_t       bus_sel,
    output logic       alu_op1_sel_bus,
    output logic       alu_op2_sel_bus,
    output logic       alu_op_low,
    output logic       alu_sel_op2_high,
    output logic       alu_sel_op2_neg,
    output logic       alu_core_cf_in,
    output logic       alu_core_R,
    output logic       alu_core_S,
    output logic       alu_core_V,
    output logic       alu_parity_in,
    input  logic       alu_core_cf_out,
    input  logic       alu_vf_out,
    input  logic       alu_parity_out
);

    state_t     r_state;
    alu_op_t    r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_cf;
    logic       r_hc;
    logic       r_pl;
    logic       r_cout;
    logic       r_vf;
    logic       r_par;
    logic [7:0] w_flags;

    assign req_ready = (r_state == ST_IDLE);

    // Flags are assembled from the live readback during READ and
    // registered together with the result at the READ -> RESP edge.
    alu_seq_flags #(
        .CF_SUB_INVERT (CF_SUB_INVERT)
    ) u_flags (
        .i_op    (r_op),
        .i_res   (alu_db_in),
        .i_opb   (r_b),
        .i_hc    (r_hc),
        .i_cout  (r_cout),
        .i_vf    (r_vf),
        .i_par   (r_par),
        .o_flags (w_flags)
    );

    // All ALU controls are registered: each transition loads the values
    // belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_op             <= OP_ADD;
            r_a              <= 8'h00;
            r_b              <= 8'h00;
            r_cf             <= 1'b0;
            r_hc             <= 1'b0;
            r_pl             <= 1'b0;
            r_cout           <= 1'b0;
            r_vf             <= 1'b0;
            r_par            <= 1'b0;
            resp_valid       <= 1'b0;
            resp_result      <= 8'h00;
            resp_flags       <= 8'h00;
            alu_db_out       <= 8'h00;
            alu_db_oe        <= 1'b0;
            bus_sel          <= BUS_HIGHZ;
            alu_op1_sel_bus  <= 1'b0;
            alu_op2_sel_bus  <= 1'b0;
            alu_op_low       <= 1'b0;
            alu_sel_op2_high <= 1'b0;
            alu_sel_op2_neg  <= 1'b0;
            alu_core_cf_in   <= 1'b0;
            alu_core_R       <= 1'b0;
            alu_core_S       <= 1'b0;
            alu_core_V       <= 1'b0;
            alu_parity_in    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op            <= req_op;
                        r_a             <= req_a;
                        r_b             <= req_b;
                        r_cf            <= req_cf;
                        alu_db_oe       <= 1'b1;
                        alu_db_out      <= req_a;
                        bus_sel         <= BUS_SHIFT;
                        alu_op1_sel_bus <= 1'b1;
                        r_state         <= ST_OP1;
                    end
                end
                ST_OP1: begin
                    alu_db_out      <= r_b;
                    alu_op1_sel_bus <= 1'b0;
                    alu_op2_sel_bus <= 1'b1;
                    r_state         <= ST_OP2;
                end
                ST_OP2: begin
                    alu_db_oe        <= 1'b0;
                    alu_db_out       <= 8'h00;
                    bus_sel          <= BUS_HIGHZ;
                    alu_op2_sel_bus  <= 1'b0;
                    alu_op_low       <= 1'b1;
                    alu_sel_op2_high <= 1'b0;
                    alu_parity_in    <= 1'b0;
                    alu_core_cf_in   <= carry_in0(r_op, r_cf);
                    {alu_core_R, alu_core_S, alu_core_V, alu_sel_op2_neg}
                                     <= op_ctrl(r_op);
                    r_state          <= ST_LOW;
                end
                ST_LOW: begin
                    // Low-nibble carry and parity chain into the high pass
                    r_hc             <= alu_core_cf_out;
                    r_pl             <= alu_parity_out;
                    alu_core_cf_in   <= alu_core_cf_out;
                    alu_parity_in    <= alu_parity_out;
                    alu_op_low       <= 1'b0;
                    alu_sel_op2_high <= 1'b1;
                    r_state          <= ST_HIGH;
                end
                ST_HIGH: begin
                    r_cout           <= alu_core_cf_out;
                    r_vf             <= alu_vf_out;
                    r_par            <= alu_parity_out;
                    alu_sel_op2_high <= 1'b0;
                    alu_core_cf_in   <= 1'b0;
                    alu_parity_in    <= 1'b0;
                    bus_sel          <= BUS_RES;
                    r_state          <= ST_READ;
                end
                ST_READ: begin
                    resp_result     <= (r_op == OP_CP) ? r_a : alu_db_in;
                    resp_flags      <= w_flags;
                    resp_valid      <= 1'b1;
                    bus_sel         <= BUS_HIGHZ;
                    alu_core_R      <= 1'b0;
                    alu_core_S      <= 1'b0;
                    alu_core_V      <= 1'b0;
                    alu_sel_op2_neg <= 1'b0;
                    r_state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_sequencer
//  Description : Self-checking bench for alu_sequencer with a behavioural
//                nibble-serial ALU and a byte-level Z80 reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    alu_op_t    req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_cf;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_result;
    logic [7:0] resp_flags;
    logic [7:0] alu_db_out;
    logic       alu_db_oe;
    logic [7:0] alu_db_in;
    bus_t       bus_sel;
    logic       alu_op1_sel_bus;
    logic       alu_op2_sel_bus;
    logic       alu_op_low;
    logic       alu_sel_op2_high;
    logic       alu_sel_op2_neg;
    logic       alu_core_cf_in;
    logic       alu_core_R;
    logic       alu_core_S;
    logic       alu_core_V;
    logic       alu_parity_in;
    logic       alu_core_cf_out;
    logic       alu_vf_out;
    logic       alu_parity_out;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    alu_sequencer #(
        .CF_SUB_INVERT (1'b1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_a            (req_a),
        .req_b            (req_b),
        .req_cf           (req_cf),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_result      (resp_result),
        .resp_flags       (resp_flags),
        .alu_db_out       (alu_db_out),
        .alu_db_oe        (alu_db_oe),
        .alu_db_in        (alu_db_in),
        .bus_sel          (bus_sel),
        .alu_op1_sel_bus  (alu_op1_sel_bus),
        .alu_op2_sel_bus  (alu_op2_sel_bus),
        .alu_op_low       (alu_op_low),
        .alu_sel_op2_high (alu_sel_op2_high),
        .alu_sel_op2_neg  (alu_sel_op2_neg),
        .alu_core_cf_in   (alu_core_cf_in),
        .alu_core_R       (alu_core_R),
        .alu_core_S       (alu_core_S),
        .alu_core_V       (alu_core_V),
        .alu_parity_in    (alu_parity_in),
        .alu_core_cf_out  (alu_core_cf_out),
        .alu_vf_out       (alu_vf_out),
        .alu_parity_out   (alu_parity_out)
    );

    // ---------------- behavioural nibble-serial ALU ----------------
    logic [7:0] m_op1 = 8'h00;
    logic [7:0] m_op2 = 8'h00;
    logic [7:0] m_res = 8'h00;
    logic [3:0] m_na;
    logic [3:0] m_nb;
    logic [3:0] m_nr;
    logic [4:0] m_sum;

    always_comb begin
        m_na  = alu_op_low ? m_op1[3:0] : m_op1[7:4];
        m_nb  = alu_op_low ? m_op2[3:0] : m_op2[7:4];
        if (alu_sel_op2_neg) m_nb = ~m_nb;
        m_sum = {1'b0, m_na} + {1'b0, m_nb} + {4'b0000, alu_core_cf_in};
        case ({alu_core_R, alu_core_S, alu_core_V})
            3'b110:  m_nr = m_na & m_nb;
            3'b010:  m_nr = m_na | m_nb;
            3'b001:  m_nr = m_na ^ m_nb;
            default: m_nr = m_sum[3:0];
        endcase
        alu_core_cf_out = m_sum[4];
        alu_vf_out      = (m_na[3] == m_nb[3]) && (m_sum[3] != m_na[3]);
        // low pass reports odd parity, high pass folds it into even parity
        alu_parity_out  = alu_op_low ? (^m_nr) : ~(alu_parity_in ^ (^m_nr));
    end

    always @(posedge clk) begin
        if (alu_op1_sel_bus && bus_sel == BUS_SHIFT) m_op1 <= alu_db_out;
        if (alu_op2_sel_bus && bus_sel == BUS_SHIFT) m_op2 <= alu_db_out;
        if (alu_op_low)            m_res[3:0] <= m_nr;
        else if (alu_sel_op2_high) m_res[7:4] <= m_nr;
    end

    assign alu_db_in = (!alu_db_oe && bus_sel == BUS_RES) ? m_res : 8'h00;

    // ---------------- byte-level Z80 reference ----------------
    function automatic logic [15:0] ref_alu(input alu_op_t op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cf);
        logic [7:0] bb, r, xy, f;
        logic       cin, sub, h, c, v;
        logic [8:0] s;
        logic [4:0] hs;
        sub = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CP);
        bb  = sub ? ~b : b;
        case (op)
            OP_ADC:        cin = cf;
            OP_SUB, OP_CP: cin = 1'b1;
            OP_SBC:        cin = ~cf;
            default:       cin = 1'b0;
        endcase
        s  = {1'b0, a} + {1'b0, bb} + {8'h00, cin};
        hs = {1'b0, a[3:0]} + {1'b0, bb[3:0]} + {4'h0, cin};
        case (op)
            OP_AND:  begin r = a & b; h = 1'b1; c = 1'b0; v = ~^r; end
            OP_OR:   begin r = a | b; h = 1'b0; c = 1'b0; v = ~^r; end
            OP_XOR:  begin r = a ^ b; h = 1'b0; c = 1'b0; v = ~^r; end
            default: begin
                r = s[7:0];
                h = hs[4] ^ sub;
                c = s[8] ^ sub;
                v = (a[7] == bb[7]) && (r[7] != a[7]);
            end
        endcase
        xy = (op == OP_CP) ? b : r;
        f  = {r[7], (r == 8'h00), xy[5], h, xy[3], v, sub, c};
        return {((op == OP_CP) ? a : r), f};
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_bus_sel"}, 32'(bus_sel), 32'(BUS_HIGHZ));
        check({tag, "_db_oe"}, 32'(alu_db_oe), 32'd0);
        check({tag, "_ctrls"},
              32'({alu_op1_sel_bus, alu_op2_sel_bus, alu_op_low, alu_sel_op2_high,
                   alu_sel_op2_neg, alu_core_cf_in, alu_core_R, alu_core_S,
                   alu_core_V, alu_parity_in}), 32'd0);
        check({tag, "_resp_data"}, 32'({resp_result, resp_flags}), 32'd0);
    endtask

    // One complete transaction; hold = cycles resp_ready stays low in RESP
    task automatic run_op(input alu_op_t op, input logic [7:0] a, input logic [7:0] b,
                          input logic cf, input int hold);
        bus_t        seq[0:5];
        logic        negs[0:5];
        logic [7:0]  dbo[0:5];
        int          k;
        logic [7:0]  r0, f0;
        logic [15:0] exp;
        check("req_ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cf = cf;
        tick();
        req_valid = 1'b0;
        sb_q.push_back(ref_alu(op, a, b, cf));
        for (k = 0; k < 20; k++) begin
            if (k < 6) begin seq[k] = bus_sel; negs[k] = alu_sel_op2_neg; dbo[k] = alu_db_out; end
            if (resp_valid) break;
            tick();
        end
        check("latency", 32'(k), 32'd5);
        check("bus_op1", 32'(seq[0]), 32'(BUS_SHIFT));
        check("bus_op2", 32'(seq[1]), 32'(BUS_SHIFT));
        check("bus_read", 32'(seq[4]), 32'(BUS_RES));
        check("db_op1_op2", 32'({dbo[0], dbo[1]}), 32'({a, b}));
        check("neg_window", 32'({negs[1], negs[2], negs[3], negs[4]}),
              (op == OP_SUB || op == OP_SBC || op == OP_CP) ? 32'b0111 : 32'b0000);
        r0 = resp_result;
        f0 = resp_flags;
        if (hold > 0) begin
            repeat (hold) tick();
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_stable", 32'({resp_result, resp_flags}), 32'({r0, f0}));
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        checks++;
        assert (sb_q.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'h0000;
        check("resp_result", 32'(resp_result), 32'(exp[15:8]));
        check("resp_flags", 32'(resp_flags), 32'(exp[7:0]));
        // handshake; a request offered here must not be taken
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        check("req_ready_hs", 32'(req_ready), 32'd0);
        tick();
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("after_hs_valid", 32'(resp_valid), 32'd0);
        check("after_hs_idle", 32'({req_ready, alu_db_oe, alu_op1_sel_bus}), 32'b100);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = OP_ADD; req_a = 8'h00;
        req_b = 8'h00; req_cf = 1'b0; resp_ready = 1'b0;
        repeat (3) tick();
        check_idle_outputs("reset");
        reset = 1'b0;
        tick();

        run_op(OP_ADD, 8'h8C, 8'h68, 1'b0, 0);
        run_op(OP_ADC, 8'hFF, 8'h00, 1'b1, 0);
        run_op(OP_SUB, 8'h10, 8'h01, 1'b0, 0);
        run_op(OP_AND, 8'hF0, 8'h3C, 1'b0, 0);
        run_op(OP_OR,  8'h01, 8'h02, 1'b0, 0);
        run_op(OP_CP,  8'h05, 8'h05, 1'b0, 3);
        run_op(OP_XOR, 8'h5A, 8'h0F, 1'b0, 0);
        run_op(OP_SBC, 8'h10, 8'h01, 1'b1, 0);
        run_op(OP_ADD, 8'h7F, 8'h01, 1'b0, 0);

        // reset while the high nibble is being computed
        req_valid = 1'b1; req_op = OP_ADD; req_a = 8'h8C; req_b = 8'h68; req_cf = 1'b0;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        check("in_high", 32'({alu_op_low, alu_sel_op2_high}), 32'b01);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle_outputs("reset_mid");
        run_op(OP_ADD, 8'h8C, 8'h68, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
